// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at launch, held in tmp_hi/tmp_lo, and committed after the busy window.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [31:0]     hi_q, lo_q, tmp_hi, tmp_lo;
    logic            tmp_keep;

    logic            launch, done, is_mdu_op;
    logic [31:0]     res_hi, res_lo;
    logic            res_keep;
    logic [63:0]     smul, umul;
    logic [31:0]     b_nz, sq, sr, uq, ur;
    logic            div_ovf;

    assign is_mdu_op = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
    assign launch    = (state == IDLE) && start && is_mdu_op;
    assign done      = (state == RUN) && (cnt == CW'(1));

    // Divisor forced non-zero so the dividers never see /0; the result is discarded anyway.
    assign b_nz    = (B == 32'd0) ? 32'd1 : B;
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign smul    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign umul    = {32'd0, A} * {32'd0, B};
    assign sq      = div_ovf ? 32'h8000_0000 : 32'($signed(A) / $signed(b_nz));
    assign sr      = div_ovf ? 32'd0 : 32'($signed(A) % $signed(b_nz));
    assign uq      = A / b_nz;
    assign ur      = A % b_nz;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        res_keep = 1'b0;
        case (MDUOp)
            OP_MULT:  {res_hi, res_lo} = smul;
            OP_MULTU: {res_hi, res_lo} = umul;
            OP_DIV: begin
                res_hi   = sr;
                res_lo   = sq;
                res_keep = (B == 32'd0);
            end
            OP_DIVU: begin
                res_hi   = ur;
                res_lo   = uq;
                res_keep = (B == 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi   <= 32'd0;
            tmp_lo   <= 32'd0;
            tmp_keep <= 1'b0;
            cnt      <= '0;
        end else if (launch) begin
            tmp_hi   <= res_hi;
            tmp_lo   <= res_lo;
            tmp_keep <= res_keep;
            cnt      <= (MDUOp == OP_MULT || MDUOp == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (done && !tmp_keep) begin
                hi_q <= tmp_hi;
                lo_q <= tmp_lo;
            end
        end else if (!start) begin
            // Moves to HI/LO only land while idle; RUN blocks them.
            if (MDUOp == OP_MTHI) hi_q <= A;
            if (MDUOp == OP_MTLO) lo_q <= A;
        end
    end

    assign busy   = (state == RUN);
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MDUOut = (MDUOp == OP_MFHI) ? hi_q :
                    (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule
